// File: rtl/sec_min_counter_if.sv
// Bus between a seconds/minutes counter and its driver: tick, mode and
// button inputs in, count value and status strobes out.
interface sec_min_counter_if;
  logic       tick;
  logic       set_mode;
  logic       inc_btn;
  logic       dec_btn;
  logic [0:5] count;
  logic       carry;
  logic       at_max;

  modport master (
    output tick, set_mode, inc_btn, dec_btn,
    input  count, carry, at_max
  );

  modport slave (
    input  tick, set_mode, inc_btn, dec_btn,
    output count, carry, at_max
  );
endinterface

// File: rtl/sec_min_counter.sv
// Modulo-60 counter: ticks advance it in RUN with a rollover carry, buttons
// step it up/down with hold-to-auto-repeat in SET.
module sec_min_counter #(
  parameter int unsigned REPEAT_DLY = 8,
  parameter int unsigned REPEAT_PER = 4
) (
  input logic               clk,
  input logic               rst_n,
  sec_min_counter_if.slave  bus
);

  typedef enum logic { ST_RUN, ST_SET } state_t;
  typedef enum logic { PH_DELAY, PH_REPEAT } phase_t;

  localparam logic [7:0] DLY_LAST = 8'(REPEAT_DLY - 1);
  localparam logic [7:0] PER_LAST = 8'(REPEAT_PER - 1);
  localparam logic [5:0] MAX_VAL  = 6'd59;

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       carry_q, carry_d;
  logic       at_max_q;
  logic [1:0] prev_q;
  logic [7:0] hold_q [2];
  logic [7:0] hold_d [2];
  phase_t     phase_q [2];
  phase_t     phase_d [2];

  logic [1:0] btn;
  logic [1:0] rise;
  logic [1:0] rep_step;
  logic       both_held;
  logic       inc_step;
  logic       dec_step;

  // Index 0 is the inc button, index 1 the dec button.
  always_comb begin
    btn       = {bus.dec_btn, bus.inc_btn};
    rise      = btn & ~prev_q;
    both_held = &btn;
    rep_step  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      hold_d[i]  = hold_q[i];
      phase_d[i] = phase_q[i];
      if (rise[i] || state_q != ST_SET || !btn[i] || both_held) begin
        hold_d[i]  = 8'd0;
        phase_d[i] = PH_DELAY;
      end else if (phase_q[i] == PH_DELAY) begin
        if (hold_q[i] == DLY_LAST) begin
          rep_step[i] = 1'b1;
          hold_d[i]   = 8'd0;
          phase_d[i]  = PH_REPEAT;
        end else begin
          hold_d[i] = hold_q[i] + 8'd1;
        end
      end else begin
        if (hold_q[i] == PER_LAST) begin
          rep_step[i] = 1'b1;
          hold_d[i]   = 8'd0;
        end else begin
          hold_d[i] = hold_q[i] + 8'd1;
        end
      end
    end
    inc_step = (state_q == ST_SET) && (rise[0] || rep_step[0]);
    dec_step = (state_q == ST_SET) && (rise[1] || rep_step[1]);
  end

  // Wrap is chosen by comparison so the value never passes through 60..63.
  always_comb begin
    state_d = bus.set_mode ? ST_SET : ST_RUN;
    count_d = count_q;
    carry_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.tick) begin
        if (count_q == MAX_VAL) begin
          count_d = 6'd0;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + 6'd1;
        end
      end
    end else if (inc_step && !dec_step) begin
      count_d = (count_q == MAX_VAL) ? 6'd0 : count_q + 6'd1;
    end else if (dec_step && !inc_step) begin
      count_d = (count_q == 6'd0) ? MAX_VAL : count_q - 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      count_q  <= 6'd0;
      carry_q  <= 1'b0;
      at_max_q <= 1'b0;
      prev_q   <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        hold_q[i]  <= 8'd0;
        phase_q[i] <= PH_DELAY;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      at_max_q <= (count_d == MAX_VAL);
      prev_q   <= btn;
      for (int i = 0; i < 2; i++) begin
        hold_q[i]  <= hold_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

  // Ascending output range keeps the MSB in bit 0 for the comparator.
  assign bus.count  = count_q;
  assign bus.carry  = carry_q;
  assign bus.at_max = at_max_q;

endmodule

// File: tb/tb_sec_min_counter.sv
// Scoreboard bench for sec_min_counter: directed scenarios plus random
// stimulus, checked against a cycle-level behavioural model.
module tb_sec_min_counter;

  localparam int DLY = 8;
  localparam int PER = 4;

  typedef struct {
    int count;
    bit carry;
    bit at_max;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sec_min_counter_if bus();

  sec_min_counter #(.REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cycle_no     = 0;

  int   m_count;
  bit   m_set;
  bit   m_prev_inc;
  bit   m_prev_dec;
  int   run_len [2];

  task automatic compareVal(input string name, input int cyc, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Behaviour in terms of how long each button has been held uninterrupted.
  function automatic exp_t modelStep(input bit r, input bit t, input bit s, input bit i, input bit d);
    exp_t e;
    bit [1:0] btn, rise, step;
    bit both, qual, auto_s;
    e.carry = 1'b0;
    if (!r) begin
      m_count = 0; m_set = 1'b0; m_prev_inc = 1'b0; m_prev_dec = 1'b0;
      run_len[0] = 0; run_len[1] = 0;
    end else begin
      btn  = {d, i};
      rise = btn & ~{m_prev_dec, m_prev_inc};
      both = i && d;
      for (int k = 0; k < 2; k++) begin
        qual = m_set && btn[k] && !both && !rise[k];
        run_len[k] = qual ? run_len[k] + 1 : 0;
        auto_s = qual && (run_len[k] >= DLY) && (((run_len[k] - DLY) % PER) == 0);
        step[k] = m_set && (rise[k] || auto_s);
      end
      if (!m_set) begin
        if (t) begin
          if (m_count == 59) begin
            m_count = 0;
            e.carry = 1'b1;
          end else begin
            m_count++;
          end
        end
      end else begin
        m_count = (m_count + int'(step[0]) - int'(step[1]) + 60) % 60;
      end
      m_set = s;
      m_prev_inc = i;
      m_prev_dec = d;
    end
    e.count  = m_count;
    e.at_max = (m_count == 59);
    e.cyc    = cycle_no;
    return e;
  endfunction

  task automatic applyStimulus(input bit r, input bit t, input bit s, input bit i, input bit d);
    @(negedge clk);
    rst_n        = r;
    bus.tick     = t;
    bus.set_mode = s;
    bus.inc_btn  = i;
    bus.dec_btn  = d;
    cycle_no++;
    exp_q.push_back(modelStep(r, t, s, i, d));
  endtask

  task automatic checkOutput(input exp_t e);
    compareVal("count",  e.cyc, int'(bus.count),  e.count);
    compareVal("carry",  e.cyc, int'(bus.carry),  int'(e.carry));
    compareVal("at_max", e.cyc, int'(bus.at_max), int'(e.at_max));
  endtask

  task automatic sampleAfterEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    int carries;
    bit s, i, d, t, r;
    bus.tick = 1'b0; bus.set_mode = 1'b0; bus.inc_btn = 1'b0; bus.dec_btn = 1'b0;

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 1);
    sampleAfterEdge();
    compareVal("reset_count",  cycle_no, int'(bus.count), 0);
    compareVal("reset_carry",  cycle_no, int'(bus.carry), 0);
    compareVal("reset_at_max", cycle_no, int'(bus.at_max), 0);

    // Single ticks up to 59, then the rollover.
    for (int n = 0; n < 59; n++) begin
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
    end
    sampleAfterEdge();
    compareVal("at59_count",  cycle_no, int'(bus.count), 59);
    compareVal("at59_at_max", cycle_no, int'(bus.at_max), 1);
    compareVal("at59_carry",  cycle_no, int'(bus.carry), 0);
    applyStimulus(1, 1, 0, 0, 0);
    sampleAfterEdge();
    compareVal("roll_count",  cycle_no, int'(bus.count), 0);
    compareVal("roll_carry",  cycle_no, int'(bus.carry), 1);
    compareVal("roll_at_max", cycle_no, int'(bus.at_max), 0);
    applyStimulus(1, 0, 0, 0, 0);
    sampleAfterEdge();
    compareVal("roll_carry_drop", cycle_no, int'(bus.carry), 0);

    applyStimulus(0, 0, 0, 0, 0);
    carries = 0;
    for (int n = 0; n < 125; n++) begin
      applyStimulus(1, 1, 0, 0, 0);
      sampleAfterEdge();
      if (bus.carry) carries++;
    end
    compareVal("tick125_count",   cycle_no, int'(bus.count), 5);
    compareVal("tick125_carries", cycle_no, carries, 2);

    // SET wrap in both directions from 0.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 1);
    sampleAfterEdge();
    compareVal("dec_wrap_count", cycle_no, int'(bus.count), 59);
    compareVal("dec_wrap_carry", cycle_no, int'(bus.carry), 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 1, 0);
    sampleAfterEdge();
    compareVal("inc_wrap_count", cycle_no, int'(bus.count), 0);
    compareVal("inc_wrap_carry", cycle_no, int'(bus.carry), 0);
    applyStimulus(1, 0, 1, 0, 0);

    // Ticks frozen in SET; simultaneous inc/dec edges cancel.
    applyStimulus(1, 0, 0, 0, 0);
    for (int n = 0; n < 9; n++) applyStimulus(1, 1, 0, 0, 0);
    for (int n = 0; n < 6; n++) applyStimulus(1, 1, 1, 0, 0);
    sampleAfterEdge();
    compareVal("frozen_count", cycle_no, int'(bus.count), 10);
    applyStimulus(1, 1, 1, 1, 1);
    sampleAfterEdge();
    compareVal("both_edge_count", cycle_no, int'(bus.count), 10);
    applyStimulus(1, 1, 1, 0, 0);

    // Auto-repeat: 21-cycle hold, then re-press restarts the delay.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    for (int n = 0; n < 21; n++) applyStimulus(1, 0, 1, 1, 0);
    sampleAfterEdge();
    compareVal("repeat21_count", cycle_no, int'(bus.count), 5);
    applyStimulus(1, 0, 1, 0, 0);
    for (int n = 0; n < 8; n++) applyStimulus(1, 0, 1, 1, 0);
    sampleAfterEdge();
    compareVal("repress8_count", cycle_no, int'(bus.count), 6);
    applyStimulus(1, 0, 1, 1, 0);
    sampleAfterEdge();
    compareVal("repress9_count", cycle_no, int'(bus.count), 7);
    applyStimulus(1, 0, 1, 0, 0);

    // Reset in the middle of a SET hold.
    applyStimulus(0, 0, 0, 0, 0);
    for (int n = 0; n < 58; n++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    for (int n = 0; n < 4; n++) applyStimulus(1, 0, 1, 1, 0);
    sampleAfterEdge();
    compareVal("hold58_count", cycle_no, int'(bus.count), 59);
    applyStimulus(0, 0, 1, 1, 0);
    sampleAfterEdge();
    compareVal("midreset_count", cycle_no, int'(bus.count), 0);
    compareVal("midreset_carry", cycle_no, int'(bus.carry), 0);
    applyStimulus(1, 1, 0, 0, 0);
    sampleAfterEdge();
    compareVal("postreset_tick", cycle_no, int'(bus.count), 1);

    s = 1'b0; i = 1'b0; d = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) != 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) s = ~s;
      if ($urandom_range(0, 14) == 0) i = ~i;
      if ($urandom_range(0, 14) == 0) d = ~d;
      applyStimulus(r, t, s, i, d);
    end

    applyStimulus(1, 0, 0, 0, 0);
    sampleAfterEdge();
    #1;
    compareVal("scoreboard_drained", cycle_no, exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sec_min_counter.md
# sec_min_counter

Modulo-60 seconds/minutes counter that produces the 6-bit value consumed by the 59-detect comparator and by the display path. In RUN it advances on a one-cycle tick strobe and emits a carry pulse on the 59->0 rollover, which drives the next stage: seconds into minutes, minutes into hours. In SET the user steps the value up or down with inc/dec buttons, including hold-to-auto-repeat, with wrap-around in both directions and no carry. One instance serves seconds and one serves minutes.

## Interface
- REPEAT_DLY, default 8: cycles a button must stay high after its rising edge before auto-repeat begins (1..255).
- REPEAT_PER, default 4: cycles between auto-repeat steps while the button stays held (1..255).
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- tick  in  1  one-cycle advance strobe; acted on only in RUN.
- set_mode  in  1  level; high requests SET, low requests RUN.
- inc_btn  in  1  synchronised, debounced level; step +1 in SET.
- dec_btn  in  1  synchronised, debounced level; step -1 in SET.
- count  out  [0:5]  current value 0..59; bit 0 is the MSB, the same ordering the 59-comparator expects.
- carry  out  1  registered one-cycle pulse on a RUN rollover 59->0.
- at_max  out  1  registered; high exactly when count == 59.

## Operation
- State machine, two states:
  - RUN -> SET when set_mode is sampled high.
  - SET -> RUN when set_mode is sampled low.
  - The state register updates one cycle after set_mode changes.
- RUN:
  - tick=1 and count<59: count+1, carry=0.
  - tick=1 and count==59: count=0, carry=1 for that one cycle.
  - tick=0: hold; carry=0.
  - Buttons are ignored.
- SET:
  - tick is ignored; carry is held 0.
  - A step is an inc rising edge or an inc auto-repeat event. The same applies to dec.
  - An inc step adds 1, with 59 wrapping to 0.
  - A dec step subtracts 1, with 0 wrapping to 59.
  - If inc and dec steps occur in the same cycle, count is unchanged.
- Edge detection:
  - Registered previous copies of inc_btn and dec_btn.
  - Rising edge = current & ~prev.
  - The prev registers update in every state.
- Auto-repeat, per button: one shared 8-bit hold counter and a phase flag.
  - Rising edge: clear the counter, phase = DELAY.
  - DELAY: when the counter reaches REPEAT_DLY-1, emit a step, clear the counter, and set phase = REPEAT.
  - REPEAT: emit a step every REPEAT_PER cycles.
  - Releasing the button, leaving SET, or both buttons held: clear the counter; no repeat steps.
- count never leaves 0..59.
  - Arithmetic is 6-bit unsigned.
  - Wrap is decided by the compare before the add or subtract; the value is never produced by overflow.
- at_max is recomputed from the next value of count, so it stays coincident with count.

## Timing
- Reset (rst_n sampled low), all outputs 0:
  - count=0, carry=0, at_max=0.
  - state=RUN, prev regs=0, hold counters=0, phase=DELAY.
- Tick latency: tick high in cycle n -> new count visible in cycle n+1. carry is high in cycle n+1 only, aligned with count=0.
- Back-to-back ticks advance the count once per cycle. Ticks never merge.
- set_mode rises in cycle n:
  - The state is SET from cycle n+1.
  - A tick in cycle n still counts.
  - A button edge in cycle n is lost, because it is seen while the state is RUN.
- A button edge in cycle n while in SET -> count changes in cycle n+1.
- First auto-repeat step: REPEAT_DLY cycles after the edge step. Each later step follows REPEAT_PER cycles after the previous one.
- A button already high when rst_n releases produces an edge in the first cycle after reset. It has no effect, because the state is RUN.
- Reset mid-operation, including during a SET hold: all state returns to the reset values on the next edge. No partial step or carry is emitted.

## Test plan
- Reset, then 59 single ticks -> count=59, at_max=1, carry=0. One more tick -> count=0, carry=1 for exactly one cycle, at_max=0.
- From reset, hold tick high for 125 cycles -> count=5, with exactly two carry pulses, each aligned with count=0.
- SET at count=0, one dec pulse -> count=59, carry stays 0. Then one inc pulse -> count=0, carry stays 0.
- SET at count=10, set_mode high with tick high throughout -> count frozen at 10. Raise inc and dec in the same cycle -> count stays 10.
- SET at count=0, with REPEAT_DLY=8 and REPEAT_PER=4, hold inc for 21 cycles:
  - Steps on cycles 1, 9, 13, 17 and 21 after the edge -> count=5.
  - Release, then re-press -> the 8-cycle delay restarts.
- SET at count=58, hold inc, assert rst_n low mid-hold -> count=0, state=RUN, no carry. After release, tick advances normally.
